// File: rtl/simon_pattern_player.sv
// Simon Says pattern player: LFSR-generated symbol store with timed one-hot LED playback.
// Optional SIMON_PLAYER_SPEEDUP_EN shortens each ON phase as the played length grows.
module simon_pattern_player #(
  parameter int          CNTS_PER_SEC = 25000000,
  parameter int          DIFFICULTY   = 6,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_New_Game,
  input  logic       i_Play,
  input  logic [3:0] i_Length,
  input  logic [3:0] i_Rd_Idx,
  output logic [1:0] o_Rd_Sym,
  output logic [3:0] o_LED,
  output logic       o_Busy,
  output logic       o_Done
);

  localparam int ON_CNTS  = CNTS_PER_SEC / 2;
  localparam int OFF_CNTS = CNTS_PER_SEC / 4;
  localparam int TW       = $clog2(CNTS_PER_SEC) + 1;

  localparam logic [3:0]    LAST_IDX = 4'(DIFFICULTY - 1);
  localparam logic [3:0]    MAX_LEN  = 4'(DIFFICULTY);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CNTS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_ON,
    S_OFF,
    S_DONE
  } state_t;

  state_t        r_state, w_state_next;
  logic [15:0]   r_lfsr;
  logic [15:0]   w_lfsr_next;
  logic [3:0]    r_idx, w_idx_next;
  logic [3:0]    r_len, w_len_next;
  logic [TW-1:0] r_timer, w_timer_next;
  logic [3:0]    r_led;
  logic [3:0]    w_play_len;
  logic [3:0]    w_led_map;
  logic          w_wr_en;
  logic [TW-1:0] w_on_last;
  logic [1:0]    w_mem [16];

  // Galois right-shift LFSR; runs in every state so the sequence depends on request timing.
  assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= w_lfsr_next;
    end
  end

  assign w_play_len = (i_Length > MAX_LEN) ? MAX_LEN : i_Length;

`ifdef SIMON_PLAYER_SPEEDUP_EN
  localparam int ON_STEP = CNTS_PER_SEC / 32;

  logic [TW-1:0] r_on_last;
  logic [TW-1:0] w_on_last_play;

  // ON length is fixed for the whole playback, so compute it once when Play is accepted.
  always_comb begin
    w_on_last_play = TW'(ON_CNTS - 1);
    if (w_play_len != 4'd0) begin
      w_on_last_play = TW'(ON_CNTS - 1 - ON_STEP * int'(w_play_len - 4'd1));
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_on_last <= '0;
    end else if (r_state == S_IDLE && !i_New_Game && i_Play) begin
      r_on_last <= w_on_last_play;
    end
  end

  assign w_on_last = r_on_last;
`else
  assign w_on_last = TW'(ON_CNTS - 1);
`endif

  // Symbol store: one register per live entry, entries past DIFFICULTY read as zero.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_mem
      if (gi < DIFFICULTY) begin : g_reg
        logic [1:0] r_sym;
        always_ff @(posedge i_Clk or negedge i_Rst_L) begin
          if (!i_Rst_L) begin
            r_sym <= 2'b00;
          end else if (w_wr_en && r_idx == 4'(gi)) begin
            r_sym <= r_lfsr[1:0];
          end
        end
        assign w_mem[gi] = r_sym;
      end else begin : g_zero
        assign w_mem[gi] = 2'b00;
      end
    end
  endgenerate

  assign o_Rd_Sym  = w_mem[i_Rd_Idx];
  assign w_led_map = 4'b0001 << w_mem[r_idx];

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
      r_len   <= 4'd0;
      r_timer <= '0;
      r_led   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_len   <= w_len_next;
      r_timer <= w_timer_next;
      r_led   <= (r_state == S_ON) ? w_led_map : 4'd0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_len_next   = r_len;
    w_timer_next = r_timer;
    w_wr_en      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_New_Game) begin
          w_state_next = S_GEN;
          w_idx_next   = 4'd0;
        end else if (i_Play) begin
          w_len_next   = w_play_len;
          w_idx_next   = 4'd0;
          w_timer_next = '0;
          w_state_next = (w_play_len == 4'd0) ? S_DONE : S_ON;
        end
      end
      S_GEN: begin
        w_wr_en    = 1'b1;
        w_idx_next = r_idx + 4'd1;
        if (r_idx == LAST_IDX) begin
          w_state_next = S_IDLE;
          w_idx_next   = 4'd0;
        end
      end
      S_ON: begin
        if (r_timer == w_on_last) begin
          w_state_next = S_OFF;
          w_timer_next = '0;
        end else begin
          w_timer_next = r_timer + TW'(1);
        end
      end
      S_OFF: begin
        if (r_timer == OFF_LAST) begin
          w_timer_next = '0;
          if (r_idx == r_len - 4'd1) begin
            w_state_next = S_DONE;
          end else begin
            w_idx_next   = r_idx + 4'd1;
            w_state_next = S_ON;
          end
        end else begin
          w_timer_next = r_timer + TW'(1);
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign o_LED  = r_led;
  assign o_Busy = (r_state == S_GEN) || (r_state == S_ON) || (r_state == S_OFF);
  assign o_Done = (r_state == S_DONE);

endmodule

// File: tb/tb_simon_pattern_player.sv
// Directed bench for simon_pattern_player at CNTS_PER_SEC=16 (ON=8, OFF=4), DIFFICULTY=6.
module tb_simon_pattern_player;

  localparam int          CPS     = 16;
  localparam int          DIFF    = 6;
  localparam logic [15:0] SEED    = 16'hACE1;
  localparam int          ON_BASE = CPS / 2;
  localparam int          OFF_LEN = CPS / 4;
`ifdef SIMON_PLAYER_SPEEDUP_EN
  localparam int          STEP    = CPS / 32;
`else
  localparam int          STEP    = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic       new_game;
  logic       play;
  logic [3:0] length;
  logic [3:0] rd_idx;
  logic [1:0] rd_sym;
  logic [3:0] led;
  logic       busy;
  logic       done;

  logic [15:0] m_lfsr;
  int          exp_sym [DIFF];
  int          n_cmp;
  int          n_fail;

  simon_pattern_player #(
    .CNTS_PER_SEC(CPS),
    .DIFFICULTY  (DIFF),
    .SEED        (SEED)
  ) dut (
    .i_Clk     (clk),
    .i_Rst_L   (rst_n),
    .i_New_Game(new_game),
    .i_Play    (play),
    .i_Length  (length),
    .i_Rd_Idx  (rd_idx),
    .o_Rd_Sym  (rd_sym),
    .o_LED     (led),
    .o_Busy    (busy),
    .o_Done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference Galois LFSR, advanced on the same edges as the design's.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SEED;
    else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_gen(input logic with_play);
    @(negedge clk);
    new_game = 1'b1;
    play     = with_play;
    length   = 4'd3;
    @(negedge clk);
    new_game = 1'b0;
    play     = 1'b0;
    for (int j = 0; j < DIFF; j++) begin
      chk("gen_busy", 32'(busy), 32'd1);
      chk("gen_led", 32'(led), 32'd0);
      exp_sym[j] = int'(m_lfsr[1:0]);
      @(negedge clk);
    end
    chk("gen_busy_end", 32'(busy), 32'd0);
    for (int j = 0; j < 3; j++) begin
      chk("idle_led", 32'(led), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    for (int j = 0; j < DIFF; j++) begin
      rd_idx = 4'(j);
      #1;
      chk("rd_sym", 32'(rd_sym), 32'(exp_sym[j]));
    end
    rd_idx = 4'd7;
    #1;
    chk("rd_oob", 32'(rd_sym), 32'd0);
    rd_idx = 4'd0;
  endtask

  // Cycle c counts from the first cycle after the Play edge; LEDs lag the FSM by one cycle.
  task automatic do_play(input logic [3:0] len_in, input int n, input int inject_at);
    int         on_len;
    int         per;
    int         last;
    int         pos;
    int         sym;
    logic [3:0] el;
    on_len = (n > 0) ? ON_BASE - (n - 1) * STEP : ON_BASE;
    per    = on_len + OFF_LEN;
    last   = n * per + 1;
    @(negedge clk);
    play   = 1'b1;
    length = len_in;
    @(negedge clk);
    play   = 1'b0;
    length = 4'd0;
    for (int c = 1; c <= last + 2; c++) begin
      el = 4'd0;
      if (c >= 2 && c <= last) begin
        pos = (c - 2) % per;
        sym = (c - 2) / per;
        if (pos < on_len) el = 4'(4'b0001 << exp_sym[sym]);
      end
      chk("play_led", 32'(led), 32'(el));
      chk("play_busy", 32'(busy), (c <= n * per) ? 32'd1 : 32'd0);
      chk("play_done", 32'(done), (c == last) ? 32'd1 : 32'd0);
      play     = (c == inject_at);
      new_game = (c == inject_at + 10) && (inject_at > 0);
      length   = (c == inject_at) ? 4'd1 : 4'd0;
      @(negedge clk);
    end
    play     = 1'b0;
    new_game = 1'b0;
    length   = 4'd0;
    for (int j = 0; j < DIFF; j++) begin
      rd_idx = 4'(j);
      #1;
      chk("rd_after_play", 32'(rd_sym), 32'(exp_sym[j]));
    end
    rd_idx = 4'd0;
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    new_game = 1'b0;
    play     = 1'b0;
    length   = 4'd0;
    rd_idx   = 4'd0;
    #2;
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sym", 32'(rd_sym), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_gen(1'b0);
    do_play(4'd3, 3, 0);
    do_play(4'd0, 0, 0);
    do_play(4'd15, 6, 0);
    do_gen(1'b1);
    do_play(4'd3, 3, 10);

    // Reset during the second ON phase (LED cycles 14..21 of a length-3 playback).
    @(negedge clk);
    play   = 1'b1;
    length = 4'd3;
    @(negedge clk);
    play   = 1'b0;
    length = 4'd0;
    repeat (16) @(negedge clk);
    chk("mid_led", 32'(led), 32'(4'(4'b0001 << exp_sym[1])));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_led", 32'(led), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_led", 32'(led), 32'd0);
      @(negedge clk);
    end
    for (int j = 0; j < 16; j++) begin
      rd_idx = 4'(j);
      #1;
      chk("post_rst_sym", 32'(rd_sym), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
